// File: rtl/test_ctrl_pkg.sv
// Shared types and constants for the test-case sequencer.
package test_ctrl_pkg;
  localparam int CASE_W     = 8;
  localparam int FAIL_CNT_W = 16;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_NEXT,
    S_DONE
  } test_ctrl_state_e;
endpackage

// File: rtl/test_ctrl_watchdog.sv
// Per-case cycle counter with timeout compare; clear has priority over enable.
module test_ctrl_watchdog #(
  parameter int CW      = 32,
  parameter int TIMEOUT = 10000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cycles,
  output logic          expired
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cycles <= '0;
    else if (clr) cycles <= '0;
    else if (en)  cycles <= cycles + CW'(1);
  end

  assign expired = en && (cycles == CW'(TIMEOUT));
endmodule

// File: rtl/test_ctrl.sv
// Test-case sequencer: owns DUT reset, per-case watchdog and failure tally.
// Optional first-failure capture ports when TEST_CTRL_FAIL_CAPTURE_EN is defined.
module test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 10000,
  parameter int CW         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CASE_W-1:0]     num_cases,
  input  logic                  case_done,
  input  logic                  chk_valid,
  input  logic                  chk_fail,
  output logic                  dut_rst,
  output logic                  case_active,
  output logic [CASE_W-1:0]     case_idx,
  output logic [CW-1:0]         cycles,
  output logic [FAIL_CNT_W-1:0] fail_cnt,
  output logic                  timeout,
  output logic                  done,
  output logic                  pass
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
  ,
  output logic [CASE_W-1:0]     first_fail_case,
  output logic [CW-1:0]         first_fail_cycle
`endif
);
  localparam int RW = $clog2(RST_CYCLES + 1);

  test_ctrl_state_e state, nxt;
  logic [CASE_W-1:0]     num_q, idx_nxt;
  logic [FAIL_CNT_W-1:0] fail_nxt;
  logic [RW-1:0]         rst_cnt;
  logic                  tmo_nxt, start_acc, fail_hit, expired;

  test_ctrl_watchdog #(.CW(CW), .TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_acc || (nxt == S_RESET)),
    .en      (state == S_RUN),
    .cycles  (cycles),
    .expired (expired)
  );

  assign fail_hit = (state == S_RUN) && chk_valid && chk_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    idx_nxt   = case_idx;
    fail_nxt  = fail_cnt;
    tmo_nxt   = timeout;
    start_acc = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: if (start) begin
        start_acc = 1'b1;
        idx_nxt   = '0;
        fail_nxt  = '0;
        tmo_nxt   = 1'b0;
        nxt       = (num_cases != '0) ? S_RESET : S_DONE;
      end
      S_RESET: if (rst_cnt == RW'(RST_CYCLES - 1)) nxt = S_RUN;
      S_RUN: begin
        if (fail_hit && fail_cnt != FAIL_CNT_MAX) fail_nxt = fail_cnt + 1'b1;
        // case_done beats a coincident timeout
        if (case_done)    nxt = (case_idx == num_q - 1'b1) ? S_DONE : S_NEXT;
        else if (expired) begin
          tmo_nxt = 1'b1;
          nxt     = S_DONE;
        end
      end
      S_NEXT: begin
        idx_nxt = case_idx + 1'b1;
        nxt     = S_RESET;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_rst     <= 1'b1;
      case_active <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      case_idx    <= '0;
      fail_cnt    <= '0;
      timeout     <= 1'b0;
      num_q       <= '0;
      rst_cnt     <= '0;
    end else begin
      dut_rst     <= (nxt != S_RUN);
      case_active <= (nxt == S_RUN);
      done        <= (nxt == S_DONE);
      pass        <= (nxt == S_DONE) && (fail_nxt == '0) && !tmo_nxt;
      case_idx    <= idx_nxt;
      fail_cnt    <= fail_nxt;
      timeout     <= tmo_nxt;
      if (start_acc) num_q <= num_cases;
      rst_cnt     <= (state == S_RESET) ? rst_cnt + 1'b1 : '0;
    end
  end

`ifdef TEST_CTRL_FAIL_CAPTURE_EN
  logic ff_vld, fail_evt;
  assign fail_evt = fail_hit || ((state == S_RUN) && expired && !case_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_vld           <= 1'b0;
      first_fail_case  <= '0;
      first_fail_cycle <= '0;
    end else if (start_acc) begin
      ff_vld           <= 1'b0;
      first_fail_case  <= '0;
      first_fail_cycle <= '0;
    end else if (fail_evt && !ff_vld) begin
      ff_vld           <= 1'b1;
      first_fail_case  <= case_idx;
      first_fail_cycle <= cycles;
    end
  end
`endif
endmodule

// File: tb/tb_test_ctrl.sv
// Scoreboard bench for test_ctrl: stimulus pushes expected end-of-sequence results,
// a negedge monitor pops and compares whenever done rises.
module tb_test_ctrl;
  import test_ctrl_pkg::*;

  logic clk, rst_n, start, start2, case_done, chk_valid, chk_fail;
  logic [7:0] num_cases;
  logic dut_rst, case_active, timeout, done, pass;
  logic [7:0] case_idx;
  logic [31:0] cycles;
  logic [15:0] fail_cnt;
  logic s_dut_rst, s_case_active, s_timeout, s_done, s_pass;
  logic [7:0] s_case_idx;
  logic [31:0] s_cycles;
  logic [15:0] s_fail_cnt;
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
  logic [7:0] ffc, s_ffc;
  logic [31:0] ffcy, s_ffcy;
`endif

  test_ctrl #(.RST_CYCLES(3), .TIMEOUT(20), .CW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cases(num_cases),
    .case_done(case_done), .chk_valid(chk_valid), .chk_fail(chk_fail),
    .dut_rst(dut_rst), .case_active(case_active), .case_idx(case_idx),
    .cycles(cycles), .fail_cnt(fail_cnt), .timeout(timeout), .done(done), .pass(pass)
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
    , .first_fail_case(ffc), .first_fail_cycle(ffcy)
`endif
  );

  test_ctrl #(.RST_CYCLES(3), .TIMEOUT(80000), .CW(32)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_cases(num_cases),
    .case_done(case_done), .chk_valid(chk_valid), .chk_fail(chk_fail),
    .dut_rst(s_dut_rst), .case_active(s_case_active), .case_idx(s_case_idx),
    .cycles(s_cycles), .fail_cnt(s_fail_cnt), .timeout(s_timeout), .done(s_done), .pass(s_pass)
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
    , .first_fail_case(s_ffc), .first_fail_cycle(s_ffcy)
`endif
  );

  typedef struct packed {
    logic [15:0] fail;
    logic        tmo;
    logic        pass;
    logic [7:0]  idx;
    logic [7:0]  ffc;
    logic [31:0] ffcy;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, passes = 0;
  logic done_d = 1'b0, s_done_d = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [15:0] f, input logic t, input logic p,
                              input logic [7:0] i, input logic [7:0] c, input logic [31:0] cy);
    exp_t e;
    e.fail = f; e.tmo = t; e.pass = p; e.idx = i; e.ffc = c; e.ffcy = cy;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [15:0] f, input logic t,
                     input logic p, input logic [7:0] i, input logic [7:0] c, input logic [31:0] cy);
    check({tag, "_fail_cnt"}, 32'(f), 32'(e.fail));
    check({tag, "_timeout"}, 32'(t), 32'(e.tmo));
    check({tag, "_pass"}, 32'(p), 32'(e.pass));
    check({tag, "_case_idx"}, 32'(i), 32'(e.idx));
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
    check({tag, "_first_fail_case"}, 32'(c), 32'(e.ffc));
    check({tag, "_first_fail_cycle"}, cy, e.ffcy);
`endif
  endtask

  always @(negedge clk) begin
    if (done && !done_d) begin
      if (q0.size() == 0) check("sb0_unexpected_done", 32'(done), 32'd0);
      else begin
        e0 = q0.pop_front();
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
        cmp("sb0", e0, fail_cnt, timeout, pass, case_idx, ffc, ffcy);
`else
        cmp("sb0", e0, fail_cnt, timeout, pass, case_idx, 8'd0, 32'd0);
`endif
      end
    end
    if (s_done && !s_done_d) begin
      if (q1.size() == 0) check("sb1_unexpected_done", 32'(s_done), 32'd0);
      else begin
        e1 = q1.pop_front();
`ifdef TEST_CTRL_FAIL_CAPTURE_EN
        cmp("sb1", e1, s_fail_cnt, s_timeout, s_pass, s_case_idx, s_ffc, s_ffcy);
`else
        cmp("sb1", e1, s_fail_cnt, s_timeout, s_pass, s_case_idx, 8'd0, 32'd0);
`endif
      end
    end
    done_d   = done;
    s_done_d = s_done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_active(output int k);
    k = 0;
    while (!case_active && k < 60) begin tick(1); k++; end
    if (!case_active) check("wait_case_active_bound", 32'(case_active), 32'd1);
  endtask

  task automatic go(input logic [7:0] n);
    start = 1'b1; num_cases = n;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b1; start = 1'b0; start2 = 1'b0; num_cases = 8'd0;
    case_done = 1'b0; chk_valid = 1'b0; chk_fail = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_dut_rst", 32'(dut_rst), 32'd1);
    check("rst_case_active", 32'(case_active), 32'd0);
    check("rst_case_idx", 32'(case_idx), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // zero cases: straight to DONE with pass, DUT reset never released
    q0.push_back(mk(16'd0, 1'b0, 1'b1, 8'd0, 8'd0, 32'd0));
    go(8'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_pass", 32'(pass), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("zero_dut_rst", 32'(dut_rst), 32'd1);
      tick(1);
    end

    // two clean cases, 3-cycle reset pulse, 4-cycle gap between cases
    go(8'd2);
    check("t1_dut_rst_after_start", 32'(dut_rst), 32'd1);
    wait_active(k);
    check("t1_first_reset_len", 32'(k), 32'd3);
    check("t1_cycles_first_run", cycles, 32'd0);
    check("t1_dut_rst_run", 32'(dut_rst), 32'd0);
    tick(4);
    check("t1_cycles_k4", cycles, 32'd4);
    case_done = 1'b1; tick(1); case_done = 1'b0;
    check("t1_next_dut_rst", 32'(dut_rst), 32'd1);
    check("t1_next_idx", 32'(case_idx), 32'd0);
    wait_active(k);
    check("t1_gap_len", 32'(k), 32'd4);
    check("t1_idx1", 32'(case_idx), 32'd1);
    check("t1_cycles_case1", cycles, 32'd0);
    q0.push_back(mk(16'd0, 1'b0, 1'b1, 8'd1, 8'd0, 32'd0));
    tick(4);
    case_done = 1'b1; tick(1); case_done = 1'b0;

    // one failing check at cycles=2, qualifier patterns, a fail with case_done
    go(8'd1);
    wait_active(k);
    tick(2);
    chk_valid = 1'b1; chk_fail = 1'b1; tick(1);
    chk_valid = 1'b1; chk_fail = 1'b0; tick(1);
    chk_valid = 1'b0; chk_fail = 1'b1; tick(1);
    check("t2_fail_cnt_mid", 32'(fail_cnt), 32'd1);
    q0.push_back(mk(16'd2, 1'b0, 1'b0, 8'd0, 8'd0, 32'd2));
    chk_valid = 1'b1; chk_fail = 1'b1; case_done = 1'b1; tick(1);
    chk_valid = 1'b0; chk_fail = 1'b0; case_done = 1'b0;

    // timeout at cycles=20
    go(8'd1);
    wait_active(k);
    q0.push_back(mk(16'd0, 1'b1, 1'b0, 8'd0, 8'd0, 32'd20));
    tick(20);
    check("t3_cycles_at_limit", cycles, 32'd20);
    check("t3_timeout_before", 32'(timeout), 32'd0);
    check("t3_done_before", 32'(done), 32'd0);
    tick(1);
    check("t3_timeout_set", 32'(timeout), 32'd1);
    check("t3_done_set", 32'(done), 32'd1);

    // case_done coinciding with the limit wins
    go(8'd1);
    wait_active(k);
    check("t4_timeout_cleared", 32'(timeout), 32'd0);
    q0.push_back(mk(16'd0, 1'b0, 1'b1, 8'd0, 8'd0, 32'd0));
    tick(20);
    case_done = 1'b1; tick(1); case_done = 1'b0;
    check("t4_no_timeout", 32'(timeout), 32'd0);

    // async reset during the second case
    go(8'd2);
    wait_active(k);
    chk_valid = 1'b1; chk_fail = 1'b1; tick(1);
    chk_valid = 1'b0; chk_fail = 1'b0;
    tick(2);
    case_done = 1'b1; tick(1); case_done = 1'b0;
    wait_active(k);
    tick(2);
    check("t5_pre_idx", 32'(case_idx), 32'd1);
    check("t5_pre_fail_cnt", 32'(fail_cnt), 32'd1);
    rst_n = 1'b0;
    #2;
    check("t5_dut_rst", 32'(dut_rst), 32'd1);
    check("t5_case_active", 32'(case_active), 32'd0);
    check("t5_case_idx", 32'(case_idx), 32'd0);
    check("t5_fail_cnt", 32'(fail_cnt), 32'd0);
    check("t5_cycles", cycles, 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_state_idle", 32'(u_dut.state), 32'(S_IDLE));
    tick(1);
    rst_n = 1'b1;
    tick(1);
    go(8'd1);
    wait_active(k);
    check("t5_restart_reset_len", 32'(k), 32'd3);
    q0.push_back(mk(16'd0, 1'b0, 1'b1, 8'd0, 8'd0, 32'd0));
    tick(2);
    case_done = 1'b1; tick(1); case_done = 1'b0;

    // 70000 failing checks saturate the tally
    start2 = 1'b1; num_cases = 8'd1; tick(1); start2 = 1'b0;
    k = 0;
    while (!s_case_active && k < 60) begin tick(1); k++; end
    check("t6_reset_len", 32'(k), 32'd3);
    chk_valid = 1'b1; chk_fail = 1'b1;
    tick(69999);
    q1.push_back(mk(16'hFFFF, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0));
    case_done = 1'b1; tick(1);
    case_done = 1'b0; chk_valid = 1'b0; chk_fail = 1'b0;

    tick(3);
    check("sb0_drained", 32'(q0.size()), 32'd0);
    check("sb1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/test_ctrl.md
# test_ctrl

Synthesizable test-case sequencer that owns the DUT reset and cycle/timeout bookkeeping for hardware-in-loop and emulation runs. It sequences `num_cases` test cases; for each case it drives a fixed-length DUT reset pulse and runs a watchdog cycle counter. It tallies check results from the stimulus/checker logic and reports pass/fail and timeout. It sits between the stimulus generator/checker and the DUT reset input.

## Interface
Parameters:
- `RST_CYCLES`, 3, DUT reset pulse length in cycles per case (≥1)
- `TIMEOUT`, 10000, per-case cycle budget before timeout
- `CW`, 32, width of cycle counter

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `start` in 1 — begin sequence (sampled in IDLE/DONE only)
- `num_cases` in 8 — number of cases, sampled on accepted `start`
- `case_done` in 1 — stimulus signals current case finished
- `chk_valid` in 1 — a check result is present this cycle
- `chk_fail` in 1 — that check failed (qualified by `chk_valid`)
- `dut_rst` out 1 — active-high DUT reset
- `case_active` out 1 — high in RUN
- `case_idx` out 8 — current case index
- `cycles` out CW — cycles since current case left reset
- `fail_cnt` out 16 — total failed checks, saturating
- `timeout` out 1 — sticky, a case exceeded `TIMEOUT`
- `done` out 1 — sequence finished
- `pass` out 1 — valid when `done`: no failures and no timeout

## Operation
- States: IDLE, RESET, RUN, NEXT, DONE.
- IDLE: `dut_rst`=1. `start` with `num_cases`≠0 → RESET; clears `case_idx`, `fail_cnt`, `timeout`. If `num_cases`=0, → DONE with `pass`=1.
- RESET: `dut_rst`=1 for exactly `RST_CYCLES` cycles. `cycles` is held at 0. → RUN.
- RUN: `dut_rst`=0, `case_active`=1, `cycles` increments each cycle.
  - `chk_valid & chk_fail` increments `fail_cnt`, saturating at 16'hFFFF.
  - `case_done` on the last case (`case_idx`==`num_cases`-1) → DONE; otherwise → NEXT.
  - `cycles`==`TIMEOUT` without `case_done` → sets `timeout`, then → DONE.
- NEXT: one cycle with `dut_rst`=1. `case_idx`++, → RESET.
- DONE: `done`=1, `dut_rst`=1. `pass` = (`fail_cnt`==0 && !`timeout`). `start` restarts as in IDLE.
- Checks with `chk_valid` outside RUN are ignored. `start` outside IDLE/DONE is ignored. `case_done` outside RUN is ignored.
- Simultaneous `case_done` and timeout in the same cycle: `case_done` wins and no timeout is flagged.
- A check arriving in the same cycle as `case_done` is counted.

## Timing
- Reset values: state IDLE, `dut_rst`=1, all other outputs 0.
- `rst_n` low at any point asynchronously forces the reset values, including mid-case.
- `start` accepted at edge N: `dut_rst` is high for edges N+1..N+RST_CYCLES, and `case_active` rises after edge N+RST_CYCLES.
- `cycles` reads 0 in the first RUN cycle and k in the (k+1)th RUN cycle.
- Between cases, `dut_rst` is high for 1+RST_CYCLES cycles.
- `done` rises the cycle after terminating `case_done` or timeout detection. `pass` is registered with it.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `TEST_CTRL_FAIL_CAPTURE_EN` defined: adds outputs `first_fail_case` (8) and `first_fail_cycle` (CW), reset to 0.
  - They latch `case_idx`/`cycles` on the first counted failure after `start`. A timeout also counts as a failure for capture if none was latched earlier.
  - Both clear on an accepted `start`.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- `test_ctrl_pkg`: state enum `test_ctrl_state_e`, `FAIL_CNT_W`=16, `CASE_W`=8, and the saturating max constant.
- One sub-module, `test_ctrl_watchdog`: clear/enable cycle counter of width CW with `TIMEOUT` compare, producing `cycles` and an `expired` pulse.
- FSM, failure tally and capture logic live in `test_ctrl`.

## Test plan
- Reset then `start`, `num_cases`=2, `RST_CYCLES`=3, `case_done` after 5 RUN cycles each → `dut_rst` high 3 cycles, then 4 cycles between cases; `case_idx` 0→1; `done`=1, `pass`=1, `fail_cnt`=0.
- `num_cases`=1, one `chk_valid&chk_fail` at `cycles`=2 → `fail_cnt`=1, `pass`=0; with macro, `first_fail_case`=0 and `first_fail_cycle`=2.
- `TIMEOUT`=20, no `case_done` → `timeout`=1 when `cycles`=20, `done` on the next cycle, `pass`=0; with `case_done` at `cycles`=20 instead → no timeout, `pass`=1.
- `start` with `num_cases`=0 → `done`=1, `pass`=1 next cycle, and `dut_rst` never drops.
- `rst_n` pulsed low mid-RUN → outputs return immediately to reset values and `state` is IDLE; a subsequent `start` runs cleanly.
- 70000 failing checks in one case → `fail_cnt` saturates at 16'hFFFF.
